// File: rtl/key_action_pkg.sv
// key_action_pkg
// Shared definitions for the keyboard action front end:
//   - keycodes of the game controls
//   - action_e: channel numbering of the default keycode table
//   - repeat_state_e: states of the delayed-auto-shift repeat FSM
//   - DEF_KEYCODES / DEF_REPEAT_MASK: default channel tables
package key_action_pkg;

    localparam logic [7:0] LEFT     = 8'h04;
    localparam logic [7:0] RIGHT    = 8'h07;
    localparam logic [7:0] ROT_L    = 8'h14;
    localparam logic [7:0] ROT_R    = 8'h1a;
    localparam logic [7:0] SOFT     = 8'h16;
    localparam logic [7:0] HOLD     = 8'h0f;
    localparam logic [7:0] CLEARALL = 8'h13;
    localparam logic [7:0] HARD     = 8'h2c;
    localparam logic [7:0] KONAMI   = 8'h18;

    // Channel index = priority (0 highest).
    typedef enum logic [2:0] {
        ACT_HARD   = 3'd0,
        ACT_ROT_L  = 3'd1,
        ACT_ROT_R  = 3'd2,
        ACT_LEFT   = 3'd3,
        ACT_RIGHT  = 3'd4,
        ACT_SOFT   = 3'd5,
        ACT_HOLD   = 3'd6,
        ACT_KONAMI = 3'd7
    } action_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } repeat_state_e;

    // Channel i occupies bits [i*8 +: 8]; channel 0 (HARD) is the LSB byte,
    // so the concatenation below lists the channels from 7 down to 0.
    localparam logic [63:0] DEF_KEYCODES = {KONAMI, HOLD, SOFT, RIGHT,
                                            LEFT, ROT_R, ROT_L, HARD};

    // LEFT and RIGHT auto-repeat.
    localparam logic [7:0] DEF_REPEAT_MASK = 8'b0001_1000;

endpackage

// File: rtl/key_autorepeat.sv
// key_autorepeat
// Delayed-auto-shift repeat generator. One shared timer follows the most
// recently pressed repeatable channel (h). After DAS_CYCLES of continuous
// hold it emits a one-cycle tick on h, then one every ARR_CYCLES.
// Ports:
//   CLK, RESET  clock, synchronous active-high reset
//   match_q     registered per-channel key match
//   rise        per-channel rising edge of match_q
//   tick        repeat event this cycle (combinational)
//   tick_ch     channel the tick belongs to
//   state       current repeat FSM state (debug)
module key_autorepeat
    import key_action_pkg::*;
#(
    parameter int                      NUM_ACTIONS = 8,
    parameter logic [NUM_ACTIONS-1:0]  REPEAT_MASK = DEF_REPEAT_MASK,
    parameter int                      CNT_W       = 20,
    parameter logic [CNT_W-1:0]        DAS_CYCLES  = 20'd500000,
    parameter logic [CNT_W-1:0]        ARR_CYCLES  = 20'd100000,
    localparam int                     ID_W        = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_ACTIONS-1:0] match_q,
    input  logic [NUM_ACTIONS-1:0] rise,
    output logic                   tick,
    output logic [ID_W-1:0]        tick_ch,
    output repeat_state_e          state
);

    repeat_state_e          state_q, state_d;
    logic [ID_W-1:0]        h_q, h_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_ACTIONS-1:0] rep_rise;
    logic [ID_W-1:0]        new_ch;

    assign rep_rise = rise & REPEAT_MASK;
    assign state    = state_q;

    always_comb begin
        new_ch = '0;
        for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
            if (rep_rise[i]) new_ch = ID_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        tick_ch = h_q;
        case (state_q)
            R_IDLE: begin
                if (|rep_rise) begin
                    state_d = R_DELAY;
                    h_d     = new_ch;
                    cnt_d   = DAS_CYCLES;
                end
            end
            default: begin
                // match_q is one-hot, so losing match on h covers both a
                // release and a switch to another key. No tick in that cycle.
                if (!match_q[h_q]) begin
                    if (|rep_rise) begin
                        state_d = R_DELAY;
                        h_d     = new_ch;
                        cnt_d   = DAS_CYCLES;
                    end else begin
                        state_d = R_IDLE;
                    end
                end else if (cnt_q == CNT_W'(1)) begin
                    tick    = 1'b1;
                    cnt_d   = ARR_CYCLES;
                    state_d = R_REPEAT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= R_IDLE;
            h_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/key_action_arbiter.sv
// key_action_arbiter
// Keyboard front end for the game control FSM. Decodes the keycode into
// NUM_ACTIONS channels, edge-detects them, adds auto-repeat ticks, latches
// pending actions and presents them one at a time on a valid/ack port.
// Ports:
//   CLK, RESET     clock, synchronous active-high reset
//   keyboardinput  current keycode, 0 = no key
//   flush          drop all pending and presented actions
//   action_ack     consumer takes the presented action
//   action_valid   an action is presented
//   action_id      channel of the presented action
//   action_repeat  presented action came from auto-repeat
//   pending        pending latch vector (debug)
//   overrun_cnt    saturating per-channel overrun counts, channel i at [i*OVR_W +: OVR_W]
//   repeat_state   repeat FSM state (debug)
//
// Handshake: the slot holds action_id/action_repeat stable while
// action_valid=1 and action_ack=0. An action is consumed on a posedge with
// action_valid=1 and action_ack=1; the next pending action may load on that
// same edge. action_ack while action_valid=0 has no effect.
module key_action_arbiter
    import key_action_pkg::*;
#(
    parameter int                                NUM_ACTIONS = 8,
    parameter int                                KEYCODE_W   = 8,
    parameter logic [NUM_ACTIONS*KEYCODE_W-1:0]  KEYCODES    = DEF_KEYCODES,
    parameter logic [NUM_ACTIONS-1:0]            REPEAT_MASK = DEF_REPEAT_MASK,
    parameter int                                CNT_W       = 20,
    parameter logic [CNT_W-1:0]                  DAS_CYCLES  = 20'd500000,
    parameter logic [CNT_W-1:0]                  ARR_CYCLES  = 20'd100000,
    parameter int                                OVR_W       = 4,
    localparam int                               ID_W        = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [KEYCODE_W-1:0]         keyboardinput,
    input  logic                         flush,
    input  logic                         action_ack,
    output logic                         action_valid,
    output logic [ID_W-1:0]              action_id,
    output logic                         action_repeat,
    output logic [NUM_ACTIONS-1:0]       pending,
    output logic [NUM_ACTIONS*OVR_W-1:0] overrun_cnt,
    output repeat_state_e                repeat_state
);

    logic [NUM_ACTIONS-1:0]            match, match_q, match_prev;
    logic [NUM_ACTIONS-1:0]            rise, tick_vec, evt;
    logic [NUM_ACTIONS-1:0]            pending_rpt;
    logic [NUM_ACTIONS-1:0]            grant_vec;
    logic [NUM_ACTIONS-1:0][OVR_W-1:0] ovr_q;
    logic                              tick;
    logic [ID_W-1:0]                   tick_ch;
    logic [ID_W-1:0]                   grant_ch;
    logic                              slot_load;

    // Keycode 0 is excluded explicitly so a zero table entry never matches.
    always_comb begin
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            match[i] = (keyboardinput != '0) &&
                       (keyboardinput == KEYCODES[i*KEYCODE_W +: KEYCODE_W]);
        end
    end

    // Both stages reload the live match during reset, so a key held across
    // reset does not produce an edge until it has been released.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            match_q    <= match;
            match_prev <= match;
        end else begin
            match_q    <= match;
            match_prev <= match_q;
        end
    end

    assign rise = match_q & ~match_prev;

    key_autorepeat #(
        .NUM_ACTIONS (NUM_ACTIONS),
        .REPEAT_MASK (REPEAT_MASK),
        .CNT_W       (CNT_W),
        .DAS_CYCLES  (DAS_CYCLES),
        .ARR_CYCLES  (ARR_CYCLES)
    ) u_autorepeat (
        .CLK     (CLK),
        .RESET   (RESET),
        .match_q (match_q),
        .rise    (rise),
        .tick    (tick),
        .tick_ch (tick_ch),
        .state   (repeat_state)
    );

    always_comb begin
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            tick_vec[i] = tick && (tick_ch == ID_W'(i));
        end
    end

    assign evt = rise | tick_vec;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        grant_ch = '0;
        for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
            if (pending[i]) grant_ch = ID_W'(i);
        end
    end

    assign slot_load = (!action_valid || action_ack) && (|pending);

    always_comb begin
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            grant_vec[i] = slot_load && (grant_ch == ID_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            action_valid  <= 1'b0;
            action_id     <= '0;
            action_repeat <= 1'b0;
            pending       <= '0;
            pending_rpt   <= '0;
            ovr_q         <= '0;
        end else if (flush) begin
            // Events arriving this cycle are dropped without counting.
            action_valid <= 1'b0;
            pending      <= '0;
            pending_rpt  <= '0;
        end else begin
            if (slot_load) begin
                action_valid  <= 1'b1;
                action_id     <= grant_ch;
                action_repeat <= pending_rpt[grant_ch];
            end else if (action_ack) begin
                action_valid <= 1'b0;
            end

            for (int i = 0; i < NUM_ACTIONS; i++) begin
                if (evt[i]) begin
                    if (pending[i] && !grant_vec[i]) begin
                        if (ovr_q[i] != {OVR_W{1'b1}}) begin
                            ovr_q[i] <= ovr_q[i] + OVR_W'(1);
                        end
                    end else begin
                        // Covers the same-edge grant: the old action moves
                        // into the slot and the new event takes its place.
                        pending[i]     <= 1'b1;
                        pending_rpt[i] <= !rise[i];
                    end
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_key_action_arbiter.sv
module tb_key_action_arbiter;
    import key_action_pkg::*;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [7:0]    keyboardinput;
    logic          flush;
    logic          action_ack;
    logic          action_valid;
    logic [2:0]    action_id;
    logic          action_repeat;
    logic [7:0]    pending;
    logic [31:0]   overrun_cnt;
    repeat_state_e repeat_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    key_action_arbiter #(
        .DAS_CYCLES (20'd8),
        .ARR_CYCLES (20'd3)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .keyboardinput (keyboardinput),
        .flush         (flush),
        .action_ack    (action_ack),
        .action_valid  (action_valid),
        .action_id     (action_id),
        .action_repeat (action_repeat),
        .pending       (pending),
        .overrun_cnt   (overrun_cnt),
        .repeat_state  (repeat_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET         = 1'b1;
        keyboardinput = 8'h00;
        flush         = 1'b0;
        action_ack    = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    // One-cycle key press followed by idle cycles.
    task automatic tap(input logic [7:0] kc, input int idle);
        keyboardinput = kc;
        step();
        keyboardinput = 8'h00;
        for (int i = 0; i < idle; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET         = 1'b1;
        keyboardinput = 8'h00;
        flush         = 1'b0;
        action_ack    = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_valid",   action_valid,  1'b0);
        check_eq("rst_id",      action_id,     3'd0);
        check_eq("rst_repeat",  action_repeat, 1'b0);
        check_eq("rst_pending", pending,       8'h00);
        check_eq("rst_ovr",     overrun_cnt,   32'h0);
        check_eq("rst_state",   repeat_state,  R_IDLE);
        RESET = 1'b0;

        // Single tap of LEFT (ch3), ack tied high: one-cycle grant 3 edges later
        action_ack    = 1'b1;
        keyboardinput = 8'h04;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 1) keyboardinput = 8'h00;
            check_eq($sformatf("tap_valid_%0d", j), action_valid, (j == 3));
            if (j == 3) begin
                check_eq("tap_id",     action_id,     3'd3);
                check_eq("tap_repeat", action_repeat, 1'b0);
            end
        end

        // Hold RIGHT (ch4) for 20 sampled cycles, ack tied high.
        // Grants at +3 (edge), then +11 (DAS=8) and every 3 after.
        do_reset();
        action_ack    = 1'b1;
        keyboardinput = 8'h07;
        for (int j = 1; j <= 26; j++) begin
            logic exp_v;
            step();
            if (j == 20) keyboardinput = 8'h00;
            exp_v = (j == 3) || (j == 11) || (j == 14) || (j == 17) || (j == 20);
            check_eq($sformatf("hold_valid_%0d", j), action_valid, exp_v);
            if (exp_v) begin
                check_eq($sformatf("hold_id_%0d", j),     action_id,     3'd4);
                check_eq($sformatf("hold_repeat_%0d", j), action_repeat, (j != 3));
            end
            if (j == 2)  check_eq("hold_state_delay",  repeat_state, R_DELAY);
            if (j == 10) check_eq("hold_state_repeat", repeat_state, R_REPEAT);
            if (j == 22) check_eq("hold_state_idle",   repeat_state, R_IDLE);
        end

        // Priority with ack low: HARD, ROT_L, HARD again.
        // Lowest index wins, so the second HARD precedes ROT_L.
        do_reset();
        tap(8'h2c, 3);
        check_eq("prio_first_valid", action_valid, 1'b1);
        check_eq("prio_first_id",    action_id,    3'd0);
        tap(8'h14, 3);
        tap(8'h2c, 3);
        check_eq("prio_held_valid", action_valid, 1'b1);
        check_eq("prio_held_id",    action_id,    3'd0);
        check_eq("prio_pending",    pending,      8'h03);
        check_eq("prio_ovr",        overrun_cnt,  32'h0);
        action_ack = 1'b1;
        step();
        check_eq("prio_ack1_valid",   action_valid, 1'b1);
        check_eq("prio_ack1_id",      action_id,    3'd0);
        check_eq("prio_ack1_pending", pending,      8'h02);
        step();
        check_eq("prio_ack2_valid",   action_valid, 1'b1);
        check_eq("prio_ack2_id",      action_id,    3'd1);
        check_eq("prio_ack2_pending", pending,      8'h00);
        step();
        check_eq("prio_ack3_valid", action_valid, 1'b0);
        action_ack = 1'b0;

        // Overrun: 4 taps of HARD with ack low -> 1 granted, 1 pending, 2 overruns
        do_reset();
        for (int t = 0; t < 4; t++) tap(8'h2c, 1);
        step();
        check_eq("ovr_valid",   action_valid,      1'b1);
        check_eq("ovr_id",      action_id,         3'd0);
        check_eq("ovr_pending", pending,           8'h01);
        check_eq("ovr_cnt2",    overrun_cnt[3:0],  4'd2);
        for (int t = 0; t < 14; t++) tap(8'h2c, 1);
        step();
        check_eq("ovr_sat",     overrun_cnt,       32'h0000000f);
        check_eq("ovr_pending2", pending,          8'h01);

        // Flush with a slot full and pending=110; a HARD edge lands on the flush edge
        do_reset();
        tap(8'h2c, 2);
        tap(8'h14, 2);
        tap(8'h1a, 2);
        check_eq("flush_pre_valid",   action_valid, 1'b1);
        check_eq("flush_pre_id",      action_id,    3'd0);
        check_eq("flush_pre_pending", pending,      8'h06);
        keyboardinput = 8'h2c;
        step();
        flush = 1'b1;
        step();
        flush         = 1'b0;
        keyboardinput = 8'h00;
        check_eq("flush_valid",   action_valid, 1'b0);
        check_eq("flush_pending", pending,      8'h00);
        for (int j = 0; j < 3; j++) step();
        check_eq("flush_lost_valid",   action_valid, 1'b0);
        check_eq("flush_lost_pending", pending,      8'h00);
        check_eq("flush_lost_ovr",     overrun_cnt,  32'h0);

        // RESET while LEFT is held: no grant until release and re-press
        do_reset();
        action_ack    = 1'b1;
        keyboardinput = 8'h04;
        step();
        step();
        step();
        check_eq("rh_first_valid", action_valid, 1'b1);
        check_eq("rh_first_id",    action_id,    3'd3);
        step();
        step();
        RESET = 1'b1;
        step();
        check_eq("rh_rst_valid",   action_valid, 1'b0);
        check_eq("rh_rst_pending", pending,      8'h00);
        step();
        check_eq("rh_rst_id",      action_id,     3'd0);
        check_eq("rh_rst_repeat",  action_repeat, 1'b0);
        check_eq("rh_rst_ovr",     overrun_cnt,   32'h0);
        RESET = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            check_eq($sformatf("rh_held_valid_%0d", j), action_valid, 1'b0);
        end
        check_eq("rh_held_state", repeat_state, R_IDLE);
        keyboardinput = 8'h00;
        step();
        step();
        step();
        keyboardinput = 8'h04;
        step();
        step();
        check_eq("rh_repress_early", action_valid, 1'b0);
        step();
        check_eq("rh_repress_valid",  action_valid,  1'b1);
        check_eq("rh_repress_id",     action_id,     3'd3);
        check_eq("rh_repress_repeat", action_repeat, 1'b0);
        keyboardinput = 8'h00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
